// File: rtl/led_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : led_pkg
//  Description : Shared types and constants for the multi-channel LED driver.
//  Revision    : 1.0 - initial release
// ============================================================================
package led_pkg;

  // Per-channel drive mode, as set by the two mode switches of that channel.
  typedef enum logic [1:0] {
    LED_OFF   = 2'b00,
    LED_ON    = 2'b01,
    LED_BLINK = 2'b10,
    LED_PWM   = 2'b11
  } led_mode_t;

  // Depth of the switch-input synchronisers.
  localparam int SYNC_STAGES = 2;

endpackage : led_pkg
`default_nettype wire

// File: rtl/led_array_ctrl_channel.sv
`default_nettype none
// ============================================================================
//  Module      : led_channel
//  Description : One LED channel. Decodes the synchronised mode into the next
//                LED level (off / on / shared blink phase / PWM compare) and
//                registers it. Disabled channels drive 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module led_channel
  import led_pkg::*;
#(
  parameter int PWM_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [1:0]       mode_s,
  input  logic [PWM_W-1:0] duty_s,
  input  logic             phase,
  input  logic [PWM_W-1:0] pwm_cnt,
  output logic             led
);

  led_mode_t mode_e;
  logic      nxt;

  assign mode_e = led_mode_t'(mode_s);

  // Select the next LED level from the channel mode.
  always_comb begin
    nxt = 1'b0;
    case (mode_e)
      LED_OFF:   nxt = 1'b0;
      LED_ON:    nxt = 1'b1;
      LED_BLINK: nxt = phase;
      // duty = max still leaves one low cycle per window; full-on is LED_ON
      LED_PWM:   nxt = (pwm_cnt < duty_s);
      default:   nxt = 1'b0;
    endcase
  end

  // Output register: forced low while the block is disabled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      led <= 1'b0;
    end else if (!en) begin
      led <= 1'b0;
    end else begin
      led <= nxt;
    end
  end

endmodule : led_channel
`default_nettype wire

// File: rtl/led_array_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : led_array_ctrl
//  Description : N_CH-channel LED driver. Synchronises the mode/duty switches,
//                runs one shared blink prescaler/phase and one shared PWM
//                counter, and feeds them to a registered decoder per channel.
//  Revision    : 1.0 - initial release
// ============================================================================
module led_array_ctrl
  import led_pkg::*;
#(
  parameter int N_CH        = 3,
  parameter int HALF_PERIOD = 5_000_000,
  parameter int CNT_W       = 25,
  parameter int PWM_W       = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    en,
  input  logic                    restart,
  input  logic [2*N_CH-1:0]       mode,
  input  logic [PWM_W*N_CH-1:0]   duty,
  output logic [N_CH-1:0]         led
);

  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(HALF_PERIOD - 1);

  logic [2*N_CH-1:0]     mode_sync [SYNC_STAGES];
  logic [PWM_W*N_CH-1:0] duty_sync [SYNC_STAGES];
  logic [2*N_CH-1:0]     mode_s;
  logic [PWM_W*N_CH-1:0] duty_s;

  logic [CNT_W-1:0]      pre_cnt;
  logic                  tick;
  logic                  phase;
  logic [PWM_W-1:0]      pwm_cnt;

  // Switch synchronisers; they keep running regardless of en.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        mode_sync[s] <= '0;
        duty_sync[s] <= '0;
      end
    end else begin
      mode_sync[0] <= mode;
      duty_sync[0] <= duty;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        mode_sync[s] <= mode_sync[s-1];
        duty_sync[s] <= duty_sync[s-1];
      end
    end
  end

  assign mode_s = mode_sync[SYNC_STAGES-1];
  assign duty_s = duty_sync[SYNC_STAGES-1];

  // End of a blink half-period.
  assign tick = (pre_cnt == PRE_LAST);

  // Shared timebase: restart beats en and a coincident tick; en=0 freezes it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_cnt <= '0;
      phase   <= 1'b0;
      pwm_cnt <= '0;
    end else if (restart) begin
      pre_cnt <= '0;
      phase   <= 1'b0;
      pwm_cnt <= '0;
    end else if (en) begin
      if (tick) begin
        pre_cnt <= '0;
        phase   <= ~phase;
      end else begin
        pre_cnt <= pre_cnt + CNT_W'(1);
      end
      pwm_cnt <= pwm_cnt + PWM_W'(1);
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    led_channel #(
      .PWM_W (PWM_W)
    ) u_channel (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (en),
      .mode_s  (mode_s[2*i +: 2]),
      .duty_s  (duty_s[PWM_W*i +: PWM_W]),
      .phase   (phase),
      .pwm_cnt (pwm_cnt),
      .led     (led[i])
    );
  end

endmodule : led_array_ctrl
`default_nettype wire

// File: tb/tb_led_array_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_led_array_ctrl
//  Description : Scoreboard bench for led_array_ctrl (HALF_PERIOD=4, PWM_W=2,
//                N_CH=3). Stimulus queues expected led values tagged with the
//                cycle they must appear in; a monitor compares every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_led_array_ctrl;

  localparam int N_CH        = 3;
  localparam int HALF_PERIOD = 4;
  localparam int CNT_W       = 3;
  localparam int PWM_W       = 2;

  typedef struct {
    int         cyc;
    logic [2:0] val;
    string      name;
  } exp_t;

  logic                  clk;
  logic                  reset_n;
  logic                  en;
  logic                  restart;
  logic [2*N_CH-1:0]     mode;
  logic [PWM_W*N_CH-1:0] duty;
  logic [N_CH-1:0]       led;

  int   cyc;
  int   checks;
  int   failures;
  exp_t exp_q[$];

  // PWM patterns {ch2,ch1,ch0} for duty {3,1,0}, indexed by the counter value
  // the channel compared against.
  logic [2:0] pwm_pat [4];

  led_array_ctrl #(
    .N_CH        (N_CH),
    .HALF_PERIOD (HALF_PERIOD),
    .CNT_W       (CNT_W),
    .PWM_W       (PWM_W)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (en),
    .restart (restart),
    .mode    (mode),
    .duty    (duty),
    .led     (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int k, input logic [2:0] v, input string nm);
    exp_t e;
    e.cyc  = cyc + k;
    e.val  = v;
    e.name = nm;
    exp_q.push_back(e);
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: compare every expectation due this cycle, flag stale ones.
  initial begin
    checks   = 0;
    failures = 0;
    forever begin
      @(negedge clk);
      #4;
      for (int i = exp_q.size() - 1; i >= 0; i--) begin
        if (exp_q[i].cyc == cyc) begin
          checks++;
          if (led !== exp_q[i].val) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%b expected=%b",
                     exp_q[i].name, cyc, led, exp_q[i].val);
          end
          exp_q.delete(i);
        end else if (exp_q[i].cyc < cyc) begin
          checks++;
          failures++;
          $display("FAIL %s cycle=%0d never sampled (due %0d)",
                   exp_q[i].name, cyc, exp_q[i].cyc);
          exp_q.delete(i);
        end
      end
    end
  end

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    pwm_pat[0] = 3'b110;
    pwm_pat[1] = 3'b100;
    pwm_pat[2] = 3'b100;
    pwm_pat[3] = 3'b000;

    reset_n = 1'b0;
    en      = 1'b0;
    restart = 1'b0;
    mode    = '0;
    duty    = '0;
    wait_neg(3);
    push(0, 3'b000, "reset_state");

    // 1: ch2 ON, ch1 BLINK, ch0 OFF
    reset_n = 1'b1;
    en      = 1'b1;
    mode    = 6'b01_10_00;
    for (int k = 1; k <= 22; k++) begin
      if (k < 3) push(k, 3'b000, "s1_latency");
      else push(k, {1'b1, (((k - 1) / 4) % 2) == 1, 1'b0}, "s1_blink");
    end
    wait_neg(22);

    // 3: disable for 10 cycles mid half-period, then resume
    en = 1'b0;
    for (int k = 1; k <= 18; k++) begin
      if (k <= 10)      push(k, 3'b000, "s3_disabled");
      else if (k <= 12) push(k, 3'b110, "s3_resume");
      else if (k <= 16) push(k, 3'b100, "s3_resume");
      else              push(k, 3'b110, "s3_resume");
    end
    wait_neg(10);
    en = 1'b1;
    wait_neg(8);

    // 4: restart lands on the edge that would toggle phase 0 -> 1
    for (int k = 1; k <= 14; k++) begin
      if (k <= 2)       push(k, 3'b110, "s4_pre");
      else if (k <= 10) push(k, 3'b100, "s4_restart");
      else              push(k, 3'b110, "s4_next_toggle");
    end
    wait_neg(5);
    restart = 1'b1;
    wait_neg(1);
    restart = 1'b0;
    wait_neg(8);

    // 5: ch0 OFF -> BLINK, changed mid-cycle
    for (int k = 1; k <= 10; k++) begin
      if (k <= 4)      push(k, 3'b100, "s5_before");
      else if (k <= 8) push(k, 3'b111, "s5_after");
      else             push(k, 3'b100, "s5_after");
    end
    wait_neg(2);
    #3;
    mode = 6'b01_10_10;
    wait_neg(8);

    // 2: all PWM, duty {3,1,0}, counters re-phased by restart
    mode    = 6'b11_11_11;
    duty    = 6'b11_01_00;
    restart = 1'b1;
    for (int k = 1; k <= 22; k++) begin
      if (k <= 2) push(k, 3'b100, "s2_latency");
      else        push(k, pwm_pat[(k - 2) % 4], "s2_pwm");
    end
    wait_neg(1);
    restart = 1'b0;
    wait_neg(22);

    // 6: asynchronous reset mid-PWM, then PWM from cleared counters
    #1;
    reset_n = 1'b0;
    push(0, 3'b000, "s6_reset_now");
    push(1, 3'b000, "s6_reset_held");
    wait_neg(2);
    reset_n = 1'b1;
    push(0, 3'b000, "s6_release");
    for (int k = 1; k <= 22; k++) begin
      if (k <= 2) push(k, 3'b000, "s6_latency");
      else        push(k, pwm_pat[(k - 1) % 4], "s6_pwm");
    end
    wait_neg(24);

    if (exp_q.size() != 0) begin
      failures += exp_q.size();
      $display("FAIL drain %0d expectations left unchecked", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_led_array_ctrl
`default_nettype wire
